// File: rtl/dispatch_rr4_pkg.sv
// Shared types and constants for the dispatch_rr4 upstream stage of the
// 4-way demultiplexer.
package dispatch_rr4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_DIR  = 1'b1;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

endpackage

// File: rtl/dispatch_rr4_lane_dec4.sv
// 2-to-4 one-hot lane decoder with enable; turns the registered lane select
// into per-lane write enables.
module lane_dec4
  import dispatch_rr4_pkg::*;
(
  input  logic                 en,
  input  logic [LANE_W-1:0]    sel,
  output logic [NUM_LANES-1:0] we
);

  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end

endmodule

// File: rtl/dispatch_rr4.sv
// Burst dispatcher: registers each accepted word with a lane select (round-robin
// or directed) and honours per-lane backpressure. Optional: DISPATCH_STALL_CNT_EN.
module dispatch_rr4
  import dispatch_rr4_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_dest,
  input  logic [3:0]           lane_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_sel,
  output logic [3:0]           out_we,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          stall_cnt
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [LEN_W-1:0]   sent_cnt_q, sent_cnt_d;
  logic               mode_q, mode_d;
  logic [LANE_W-1:0]  rr_q, rr_d;
  logic [LANE_W-1:0]  out_sel_q, out_sel_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic sel_ready;
  logic send;
  logic accept;

  assign sel_ready = lane_ready[out_sel_q];
  assign send      = out_valid_q & sel_ready;

  // Single-entry output register: a send frees the slot in the same cycle it
  // can be refilled, so back-to-back words flow at one per cycle.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_cnt_d   = acc_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    mode_d      = mode_q;
    rr_d        = rr_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          len_d      = cfg_len;
          mode_d     = cfg_mode;
          acc_cnt_d  = '0;
          sent_cnt_d = '0;
          rr_d       = '0;
          state_d    = (cfg_len != '0) ? RUN : DONE;
        end
      end

      RUN: begin
        in_ready = (acc_cnt_q < len_q) & (~out_valid_q | sel_ready);
        accept   = in_valid & in_ready;

        if (send) begin
          sent_cnt_d  = sent_cnt_q + 1'b1;
          out_valid_d = 1'b0;
          if (sent_cnt_d == len_q) state_d = DONE;
        end

        if (accept) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          out_sel_d   = (mode_q == MODE_DIR) ? in_dest : rr_q;
          acc_cnt_d   = acc_cnt_q + 1'b1;
          if (mode_q == MODE_RR) rr_d = rr_q + 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      sent_cnt_q  <= '0;
      mode_q      <= MODE_RR;
      rr_q        <= '0;
      out_sel_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_cnt_q   <= acc_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      mode_q      <= mode_d;
      rr_q        <= rr_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  lane_dec4 u_lane_dec4 (
    .en  (out_valid_q),
    .sel (out_sel_q),
    .we  (out_we)
  );

  assign out_data = out_data_q;
  assign out_sel  = out_sel_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

`ifdef DISPATCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles a held word waits on its lane; kept across bursts.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && cfg_start) begin
      stall_cnt_d = '0;
    end else if (out_valid_q && !sel_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dispatch_rr4.sv
// Randomized self-checking bench for dispatch_rr4 against a transaction-level
// model of the burst dispatcher (honours DISPATCH_STALL_CNT_EN when defined).
module tb_dispatch_rr4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic        cfg_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_dest = '0;
  logic [3:0]  lane_ready = '0;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic [3:0]  out_we;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  int checkCount = 0;
  int errorCount = 0;
  int doneSeen   = 0;

  // Reference model: burst progress counted in words, one held word at most.
  int m_state = M_IDLE;
  int m_len   = 0;
  int m_mode  = 0;
  int m_acc   = 0;
  int m_sent  = 0;
  int m_stall = 0;
  bit m_hv    = 1'b0;
  int m_hl    = 0;
  int m_hd    = 0;

  dispatch_rr4 #(.WIDTH(16), .LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_len    (cfg_len),
    .cfg_mode   (cfg_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .lane_ready (lane_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_we     (out_we),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_state = M_IDLE;
    m_len   = 0;
    m_mode  = 0;
    m_acc   = 0;
    m_sent  = 0;
    m_stall = 0;
    m_hv    = 1'b0;
    m_hl    = 0;
    m_hd    = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"},  in_ready,  0);
    checkOutput({tag, "_out_we"},    out_we,    0);
    checkOutput({tag, "_out_data"},  out_data,  0);
    checkOutput({tag, "_out_sel"},   out_sel,   0);
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_done"},      done,      0);
    checkOutput({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  // Drives one cycle of inputs, checks outputs against the model, then advances
  // the model by the rules of one clock edge.
  task automatic applyStimulus(input logic st, input logic [7:0] ln, input logic md,
                               input logic v, input logic [15:0] d, input logic [1:0] dst,
                               input logic [3:0] lr);
    bit expReady;
    bit sendNow;
    bit accNow;
    @(negedge clk);
    cfg_start  = st;
    cfg_len    = ln;
    cfg_mode   = md;
    in_valid   = v;
    in_data    = d;
    in_dest    = dst;
    lane_ready = lr;
    #1;
    expReady = (m_state == M_RUN) && (m_acc < m_len) && (!m_hv || lr[m_hl]);
    checkOutput("in_ready", in_ready, expReady);
    checkOutput("out_we", out_we, m_hv ? (32'd1 << m_hl) : 32'd0);
    if (m_hv) begin
      checkOutput("out_sel", out_sel, m_hl);
      checkOutput("out_data", out_data, m_hd);
    end
    checkOutput("busy", busy, m_state == M_RUN);
    checkOutput("done", done, m_state == M_DONE);
    checkOutput("stall_cnt", stall_cnt, m_stall);
    if (done) doneSeen++;

    case (m_state)
      M_IDLE: begin
        if (st) begin
          m_len   = ln;
          m_mode  = md;
          m_acc   = 0;
          m_sent  = 0;
`ifdef DISPATCH_STALL_CNT_EN
          m_stall = 0;
`endif
          m_state = (ln != 0) ? M_RUN : M_DONE;
        end
      end
      M_RUN: begin
        sendNow = m_hv && lr[m_hl];
        accNow  = v && expReady;
`ifdef DISPATCH_STALL_CNT_EN
        if (m_hv && !lr[m_hl] && m_stall < 65535) m_stall++;
`endif
        if (sendNow) begin
          m_sent++;
          m_hv = 1'b0;
          if (m_sent == m_len) m_state = M_DONE;
        end
        if (accNow) begin
          m_hv = 1'b1;
          m_hd = d;
          m_hl = (m_mode == 1) ? int'(dst) : (m_acc % 4);
          m_acc++;
        end
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  // Runs a whole burst: start pulse, then per-cycle inputs chosen by scenario,
  // until the model is back in idle; exactly one done pulse is expected.
  task automatic runBurst(input int scen, input int len, input int mode, input int maxCyc);
    logic        st;
    logic [7:0]  ln;
    logic        v;
    logic [15:0] d;
    logic [1:0]  dst;
    logic [3:0]  lr;
    doneSeen = 0;
    applyStimulus(1'b1, 8'(len), 1'(mode), 1'b0, 16'h0, 2'd0, 4'hF);
    for (int c = 0; c < maxCyc && m_state != M_IDLE; c++) begin
      st = 1'b0; ln = 8'd0; v = 1'b1; dst = 2'd0; lr = 4'hF;
      d  = 16'(m_acc + 1);
      case (scen)
        1: begin
          d = 16'(16'h100 + m_acc);
          if (c >= 2 && c <= 6) lr = 4'b1101;
        end
        2: begin
          d   = 16'(16'h200 + m_acc);
          dst = (m_acc < 2) ? 2'd3 : 2'd0;
        end
        3: begin
          st = (c == 1);
          ln = 8'd9;
        end
        4: begin
          v   = ($urandom_range(0, 9) < 7);
          d   = 16'($urandom);
          dst = 2'($urandom);
          lr  = 4'($urandom) | 4'($urandom);
          st  = ($urandom_range(0, 9) == 0);
          ln  = 8'($urandom_range(0, 12));
        end
        default: ;
      endcase
      applyStimulus(st, ln, 1'b0, v, d, dst, lr);
    end
    checkOutput("done_pulses", doneSeen, 1);
  endtask

  initial begin
    #2;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    // Idle with no start: nothing moves.
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 16'h55, 2'd0, 4'hF);

    // Round-robin back-to-back burst of six.
    runBurst(0, 6, 0, 40);

    // Lane 1 stalled for five cycles while holding word 2.
    runBurst(1, 4, 0, 40);
`ifdef DISPATCH_STALL_CNT_EN
    checkOutput("bp_stall_total", stall_cnt, 5);
`else
    checkOutput("bp_stall_total", stall_cnt, 0);
`endif

    // Directed destinations 3,3,0.
    runBurst(2, 3, 1, 40);

    // Zero-length burst.
    runBurst(0, 0, 0, 10);

    // Asynchronous reset after two of five words.
    doneSeen = 0;
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 16'h0, 2'd0, 4'hF);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 16'hA1, 2'd0, 4'hF);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 16'hA2, 2'd0, 4'hF);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 16'h0, 2'd0, 4'hF);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 16'h0, 2'd0, 4'hF);
    checkOutput("midrst_no_done", doneSeen, 0);
    runBurst(0, 2, 0, 20);

    // Start pulse with len 9 during a len 3 burst is ignored.
    runBurst(3, 3, 0, 40);

    // Randomized bursts.
    for (int b = 0; b < 25; b++) begin
      runBurst(4, $urandom_range(0, 12), $urandom_range(0, 1), 400);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/dispatch_rr4.md
Name: dispatch_rr4

Overview:
- Upstream stage of the 4-way data demultiplexer.
- Accepts a burst of words on a valid/ready input stream and registers each word with a 2-bit lane select. Presents that word to the demux and to per-lane write enables.
- Lane is chosen round-robin or taken from a per-word destination field.
- Respects per-lane backpressure and reports burst completion.

Parameters:
WIDTH, 16, data word width (matches demux data width)
LEN_W, 8, width of burst length and word counters

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
cfg_start  input  1  burst start pulse; honoured only in IDLE
cfg_len  input  LEN_W  words in burst, latched on start
cfg_mode  input  1  0 = round-robin lanes, 1 = directed (in_dest), latched on start
in_valid  input  1  input word valid
in_ready  output  1  input word accepted when in_valid & in_ready
in_data  input  WIDTH  input word
in_dest  input  2  destination lane, used only when mode = 1
lane_ready  input  4  per-lane consumer ready
out_data  output  WIDTH  registered word, drives demux data input
out_sel  output  2  registered lane, drives demux select
out_we  output  4  one-hot lane write enable
busy  output  1  high in RUN
done  output  1  one-cycle pulse at burst end
stall_cnt  output  16  backpressure stall cycles (see Optional Feature)

Behaviour:
- Reset: asynchronous, active-high, allowed at any time including mid-burst. It clears all state and drops any held word; no partial completion is reported. Reset values:
  - state = IDLE
  - out_data = 0, out_sel = 0, out_we = 0, out_valid (internal) = 0
  - in_ready = 0, busy = 0, done = 0, stall_cnt = 0
  - counters = 0, rr pointer = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 0.
  - On cfg_start: latch len and mode; clear acc_cnt, sent_cnt and rr pointer.
  - len != 0 → RUN. len == 0 → DONE.
- RUN:
  - Output handshake: a word is sent when out_valid & lane_ready[out_sel].
  - in_ready = (acc_cnt < len) & (!out_valid | lane_ready[out_sel]). This is a single-entry pipeline register with same-cycle refill, so sustained rate is 1 word/cycle when the target lanes are ready.
  - On accept: out_data <= in_data; out_valid <= 1.
    - out_sel <= rr pointer (mode 0) or in_dest (mode 1).
    - acc_cnt++.
    - rr pointer increments mod 4 on each accept (wraps 3→0); unchanged in mode 1.
  - Send without accept in the same cycle: out_valid <= 0.
  - On send: sent_cnt++. When sent_cnt reaches len → DONE (evaluated in the same cycle as the final send).
- DONE: done = 1 for exactly one cycle, then → IDLE.
- out_we[i] = out_valid & (out_sel == i). It is combinational from registers and independent of lane_ready, so a held word stays asserted until taken.
- out_data, out_sel and out_we are stable while out_valid & !lane_ready[out_sel].
- busy = (state == RUN).
- cfg_start is ignored outside IDLE. A simultaneous cfg_start and DONE is also ignored.
- Directed mode: a stalled lane blocks all lanes (in-order, no bypass).
- Latency: input accept to out_we = 1 cycle.

Optional Feature:
- Macro: DISPATCH_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle where out_valid & !lane_ready[out_sel].
  - Saturates at 16'hFFFF.
  - Cleared on cfg_start accepted in IDLE.
  - Holds its value between bursts.
- Undefined: stall_cnt is tied to 0 and no counter logic is present. The port list is identical in both builds.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2)
  - MODE_RR = 1'b0, MODE_DIR = 1'b1
  - NUM_LANES = 4, LANE_W = 2
- Sub-module lane_dec4: 2-to-4 one-hot decoder with enable, producing out_we.
- Counters and FSM stay in the top module.

Test Plan:
- RR burst: len = 6, mode 0, lane_ready = 4'hF, data 1..6 back-to-back →
  - out_sel 0,1,2,3,0,1 on consecutive cycles
  - first out_we one cycle after first accept
  - done pulse 1 cycle after the 6th send
  - in_ready low after 6 accepts
- Backpressure: len = 4, mode 0, lane_ready[1] = 0 for 5 cycles →
  - word 2 held on lane 1 with stable data/sel/we
  - in_ready = 0 during the hold
  - stall_cnt = 5 with DISPATCH_STALL_CNT_EN, 0 without
- Directed: mode 1, len = 3, in_dest 3,3,0 →
  - out_we 4'b1000, 4'b1000, 4'b0001
  - rr pointer unused
- Zero length: cfg_start with len = 0 →
  - DONE next cycle, done pulse, no in_ready assertion, no out_we
- Reset mid-burst: assert rst after 2 of 5 words →
  - all outputs reset asynchronously, no done pulse
  - a new cfg_start with len = 2 completes normally starting at lane 0
- Start while busy: cfg_start pulse with len = 9 during RUN of len = 3 →
  - ignored; burst ends after 3 words; done pulses once
